// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Used by mem_port_arbiter and rr_arb2.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_t;

   typedef enum logic {
      SRC_IF,
      SRC_D
   } src_t;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_req_t;

   // Fetches always read a full word.
   localparam logic [3:0] FETCH_BE = 4'b1111;

   function automatic mem_req_t fetch_req(input logic [31:0] addr);
      mem_req_t r;
      r.we    = 1'b0;
      r.be    = FETCH_BE;
      r.addr  = addr;
      r.wdata = '0;
      return r;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; combinational, the last-grant
// pointer is kept by the parent. Bit 0 = fetch, bit 1 = data.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  src_t       last_gnt,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = '0;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last_gnt == SRC_D) ? 2'b01 : 2'b10;
         default: gnt = '0;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between fetch and load/store ports,
// one transaction in flight. Define ARB_TIMEOUT_EN to enable the abort timer.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [3:0]  d_be,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic        m_req,
   output logic        m_we,
   output logic [3:0]  m_be,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic        m_gnt,
   input  logic        m_rvalid,
   input  logic [31:0] m_rdata,
   output logic        busy
);

   if (TIMEOUT_CYC < 2) begin : g_bad_timeout
      $error("mem_port_arbiter: TIMEOUT_CYC must be >= 2");
   end

   arb_state_t  state_q, state_d;
   src_t        last_q, last_d;
   src_t        owner_q, owner_d;
   mem_req_t    mreq_q, mreq_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  arb_gnt;
   logic        timeout_hit;
   logic        resp_if, resp_d;

   rr_arb2 u_arb (
      .req      ({d_req, if_req}),
      .last_gnt (last_q),
      .gnt      (arb_gnt)
   );

   assign if_gnt = (state_q == IDLE) && arb_gnt[0];
   assign d_gnt  = (state_q == IDLE) && arb_gnt[1];

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      owner_d = owner_q;
      mreq_d  = mreq_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (arb_gnt[1]) begin
               state_d = ISSUE;
               owner_d = SRC_D;
               mreq_d  = '{we: d_we, be: d_be, addr: d_addr, wdata: d_wdata};
            end else if (arb_gnt[0]) begin
               state_d = ISSUE;
               owner_d = SRC_IF;
               mreq_d  = fetch_req(if_addr);
            end
         end
         ISSUE: begin
            // m_rvalid is deliberately not looked at here.
            if (timeout_hit) begin
               state_d = RESP;
               rdata_d = '0;
            end else if (m_gnt) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (m_rvalid) begin
               state_d = RESP;
               rdata_d = m_rdata;
            end else if (timeout_hit) begin
               state_d = RESP;
               rdata_d = '0;
            end
         end
         RESP: begin
            state_d = IDLE;
            last_d  = owner_q;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= SRC_D;
         owner_q <= SRC_IF;
         mreq_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         mreq_q  <= mreq_d;
         rdata_q <= rdata_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   assign timeout_hit = (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (state_q == IDLE) begin
         cnt_d = '0;
      end else if (state_q == ISSUE || state_q == WAIT) begin
         cnt_d = cnt_q + 1'b1;
      end
      // Any RESP entry other than a real m_rvalid is an abort.
      if (state_q != RESP && state_d == RESP) begin
         err_d = !(state_q == WAIT && m_rvalid);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign if_err = resp_if && err_q;
   assign d_err  = resp_d && err_q;
`else
   assign timeout_hit = 1'b0;
   assign if_err      = 1'b0;
   assign d_err       = 1'b0;
`endif

   assign resp_if   = (state_q == RESP) && (owner_q == SRC_IF);
   assign resp_d    = (state_q == RESP) && (owner_q == SRC_D);
   assign if_rvalid = resp_if;
   assign d_rvalid  = resp_d;
   assign if_rdata  = rdata_q;
   assign d_rdata   = rdata_q;

   assign m_req   = (state_q == ISSUE);
   assign m_we    = mreq_q.we;
   assign m_be    = mreq_q.be;
   assign m_addr  = mreq_q.addr;
   assign m_wdata = mreq_q.wdata;
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter (timeout checks
// follow ARB_TIMEOUT_EN).
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_gnt, if_rvalid, if_err;
   logic [31:0] if_addr, if_rdata;
   logic        d_req, d_we, d_gnt, d_rvalid, d_err;
   logic [3:0]  d_be;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        m_req, m_we, m_gnt, m_rvalid;
   logic [3:0]  m_be;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic        busy;

   always #5 clk = ~clk;

   mem_port_arbiter #(.TIMEOUT_CYC(8)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
   );

   typedef struct {
      logic        ir;
      logic [31:0] ia;
      logic        dr;
      logic        dwe;
      logic [3:0]  dbe;
      logic [31:0] da;
      logic [31:0] dwd;
      int          gdly;
      int          rdly;
      logic [31:0] rd;
      logic        exp_d;
      mem_req_t    exp_m;
   } vec_t;

   int total = 0;
   int bad   = 0;
   vec_t vt[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_m(input string tag, input mem_req_t e);
      chk({tag, "_mreq"}, 32'(m_req), 32'd1);
      chk({tag, "_mwe_be"}, 32'({m_we, m_be}), 32'({e.we, e.be}));
      chk({tag, "_maddr"}, m_addr, e.addr);
      chk({tag, "_mwdata"}, m_wdata, e.wdata);
   endtask

   // Called at +1 after the grant edge; returns at +1 after the edge into RESP.
   task automatic serve(input int gdly, input int rdly, input logic [31:0] data,
                        input mem_req_t e, input string tag);
      for (int i = 0; i < gdly; i++) begin
         @(negedge clk);
         chk_m({tag, "_hold"}, e);
         chk({tag, "_nognt"}, 32'({if_gnt, d_gnt}), 32'd0);
         tick();
      end
      m_gnt = 1'b1;
      @(negedge clk);
      chk_m({tag, "_issue"}, e);
      chk({tag, "_nognt_i"}, 32'({if_gnt, d_gnt}), 32'd0);
      tick();
      m_gnt = 1'b0;
      for (int i = 1; i < rdly; i++) begin
         @(negedge clk);
         chk({tag, "_wait"}, 32'({m_req, if_rvalid, d_rvalid, if_gnt, d_gnt}), 32'd0);
         tick();
      end
      m_rvalid = 1'b1;
      m_rdata  = data;
      tick();
      m_rvalid = 1'b0;
      m_rdata  = 32'h0BAD_0BAD;
   endtask

   task automatic chk_resp(input logic exp_d, input logic [31:0] data, input string tag);
      @(negedge clk);
      chk({tag, "_rvalid"}, 32'({if_rvalid, d_rvalid}), exp_d ? 32'd1 : 32'd2);
      chk({tag, "_err"}, 32'({if_err, d_err}), 32'd0);
      chk({tag, "_rdata"}, exp_d ? d_rdata : if_rdata, data);
      tick();
      chk({tag, "_idle"}, 32'({busy, if_rvalid, d_rvalid}), 32'd0);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      if_req  = v.ir;  if_addr = v.ia;
      d_req   = v.dr;  d_we = v.dwe; d_be = v.dbe; d_addr = v.da; d_wdata = v.dwd;
      @(negedge clk);
      chk({tag, "_gnt"}, 32'({d_gnt, if_gnt}), v.exp_d ? 32'd2 : 32'd1);
      tick();
      if_req = 1'b0;
      d_req  = 1'b0;
      serve(v.gdly, v.rdly, v.rd, v.exp_m, tag);
      chk_resp(v.exp_d, v.rd, tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      mem_req_t e;
      int       n;
      logic     ok;

      vt[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        0, 2, 32'hDEADBEEF, 1'b0, '{1'b0, 4'hF, 32'h100, 32'h0}};
      vt[1] = '{1'b1, 32'h104, 1'b1, 1'b0, 4'hF, 32'h300, 32'h55,       1, 1, 32'h3000_0001, 1'b1, '{1'b0, 4'hF, 32'h300, 32'h55}};
      vt[2] = '{1'b1, 32'h108, 1'b1, 1'b0, 4'hF, 32'h304, 32'h0,        0, 3, 32'h0000_0108, 1'b0, '{1'b0, 4'hF, 32'h108, 32'h0}};
      vt[3] = '{1'b0, 32'h0,   1'b1, 1'b1, 4'hC, 32'h208, 32'hCAFEF00D, 5, 2, 32'h0,         1'b1, '{1'b1, 4'hC, 32'h208, 32'hCAFEF00D}};
      vt[4] = '{1'b0, 32'h0,   1'b1, 1'b0, 4'h1, 32'h20C, 32'h0,        0, 1, 32'h8000_00FF, 1'b1, '{1'b0, 4'h1, 32'h20C, 32'h0}};
      vt[5] = '{1'b1, 32'h10C, 1'b1, 1'b1, 4'h3, 32'h210, 32'h77,       2, 1, 32'h1111_2222, 1'b0, '{1'b0, 4'hF, 32'h10C, 32'h0}};
      vt[6] = '{1'b1, 32'h110, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,        0, 1, 32'hFFFF_FFFF, 1'b0, '{1'b0, 4'hF, 32'h110, 32'h0}};
      vt[7] = '{1'b1, 32'h114, 1'b1, 1'b0, 4'hF, 32'h214, 32'h0,        0, 2, 32'h1357_9BDF, 1'b1, '{1'b0, 4'hF, 32'h214, 32'h0}};

      rst = 1'b1;
      if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
      m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = 32'h0BAD_0BAD;
      tick();
      tick();
      @(negedge clk);
      chk("rst_ctrl", 32'({busy, m_req, if_gnt, d_gnt, if_rvalid, d_rvalid, if_err, d_err}), 32'd0);
      chk("rst_maddr", m_addr, 32'd0);
      chk("rst_mfields", 32'({m_we, m_be}) | m_wdata, 32'd0);
      chk("rst_rdata", if_rdata | d_rdata, 32'd0);
      tick();
      rst = 1'b0;

      // Both requesters rise in the first cycle after reset: fetch wins, data waits.
      if_req = 1'b1; if_addr = 32'h400;
      d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h204; d_wdata = 32'h1234;
      @(negedge clk);
      chk("tie_first_gnt", 32'({d_gnt, if_gnt}), 32'd1);
      tick();
      if_req = 1'b0;
      serve(0, 2, 32'hA5A5_0001, '{1'b0, 4'hF, 32'h400, 32'h0}, "tie_if");
      chk_resp(1'b0, 32'hA5A5_0001, "tie_if");
      @(negedge clk);
      chk("tie_second_gnt", 32'({d_gnt, if_gnt}), 32'd2);
      tick();
      d_req = 1'b0;
      serve(0, 1, 32'h0, '{1'b1, 4'b0011, 32'h204, 32'h1234}, "tie_d");
      chk_resp(1'b1, 32'h0, "tie_d");

      for (int i = 0; i < 8; i++) run_vec(vt[i], $sformatf("v%0d", i));

      // Both held high across six transactions; one grant stalls m_gnt 5 cycles.
      if_req = 1'b1; if_addr = 32'h500;
      d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h600; d_wdata = 32'h0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk($sformatf("rr%0d_gnt", k), 32'({d_gnt, if_gnt}), (k % 2 == 1) ? 32'd2 : 32'd1);
         tick();
         e = (k % 2 == 1) ? '{1'b0, 4'hF, 32'h600, 32'h0} : '{1'b0, 4'hF, 32'h500, 32'h0};
         serve((k == 2) ? 5 : 0, 1, 32'h1000 + 32'(k), e, $sformatf("rr%0d", k));
         chk_resp(k % 2 == 1, 32'h1000 + 32'(k), $sformatf("rr%0d", k));
      end
      if_req = 1'b0;
      d_req  = 1'b0;

      // Leave lastGnt at fetch, then reset in WAIT with a late m_rvalid.
      run_vec(vt[6], "pre_rst");
      if_req = 1'b1; if_addr = 32'h700;
      @(negedge clk);
      chk("wrst_gnt", 32'({d_gnt, if_gnt}), 32'd1);
      tick();
      if_req = 1'b0;
      m_gnt = 1'b1;
      tick();
      m_gnt = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_rvalid = 1'b1;
      m_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      chk("wrst_ctrl", 32'({busy, m_req, if_rvalid, d_rvalid, if_gnt, d_gnt}), 32'd0);
      chk("wrst_maddr", m_addr, 32'd0);
      chk("wrst_rdata", if_rdata, 32'd0);
      tick();
      m_rvalid = 1'b0;
      m_rdata = 32'h0BAD_0BAD;
      @(negedge clk);
      chk("wrst_late_rvalid", 32'({busy, if_rvalid, d_rvalid}), 32'd0);
      tick();
      if_req = 1'b1; if_addr = 32'h704;
      d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h708; d_wdata = 32'h0;
      @(negedge clk);
      chk("wrst_lastgnt_tie", 32'({d_gnt, if_gnt}), 32'd1);
      tick();
      if_req = 1'b0;
      d_req  = 1'b0;
      serve(0, 1, 32'h2468_ACE0, '{1'b0, 4'hF, 32'h704, 32'h0}, "wrst_tx");
      chk_resp(1'b0, 32'h2468_ACE0, "wrst_tx");

      // Memory that never answers.
      d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h800; d_wdata = 32'h0;
      @(negedge clk);
      chk("to_gnt", 32'({d_gnt, if_gnt}), 32'd2);
      tick();
      d_req = 1'b0;
`ifdef ARB_TIMEOUT_EN
      n = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (d_rvalid) break;
         n++;
         tick();
      end
      chk("to_cycles", 32'(n), 32'd8);
      chk("to_err", 32'({d_rvalid, d_err, if_rvalid, m_req}), 32'b1100);
      chk("to_rdata", d_rdata, 32'd0);
      tick();
      chk("to_idle", 32'(busy), 32'd0);
`else
      ok = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (!busy || d_rvalid || d_err) ok = 1'b0;
         tick();
      end
      chk("no_to_busy", 32'(ok), 32'd1);
      n = 0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("no_to_rst", 32'({busy, m_req}), 32'(n));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
